spis_cpu: RTL and testbench

SPIS_CPU -- requirements
Module: spis_cpu

---
 rtl/spis_cpu.sv | 144 ++++++++++++++
 tb/tb_spis_cpu.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spis_cpu.sv
// SPIS_CPU: a tiny accumulator CPU. Each instruction is two bytes and takes
// exactly three cycles (opcode fetch, operand fetch, execute) on a shared 8-bit bus.
module spis_cpu #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clock,
    input  logic        reset,
    inout  wire  [7:0]  dataBus,
    output logic [11:0] addressBus,
    output logic        write,
    output logic        sync
);

    typedef enum logic [1:0] {
        FETCH1 = 2'd0,
        FETCH2 = 2'd1,
        EXEC   = 2'd2,
        HALT   = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        OP_LDA = 4'h0, OP_STA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
        OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_LDI = 4'h7,
        OP_JMP = 4'h8, OP_JZ  = 4'h9, OP_JC  = 4'hA, OP_JNZ = 4'hB,
        OP_ADC = 4'hC, OP_SHR = 4'hD, OP_NOP = 4'hE, OP_HLT = 4'hF
    } opcode_t;

    state_t      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  ir_q, ir_d;
    logic [7:0]  opnd_q, opnd_d;
    logic        z_q, z_d;
    logic        c_q, c_d;

    logic        writeEn;
    logic        updateZ;
    opcode_t     opcode;
    logic [11:0] operandAddr;

    assign opcode      = opcode_t'(ir_q[7:4]);
    assign operandAddr = {ir_q[3:0], opnd_q};

    // Reset must win even mid-STA, so the bus is released whenever reset is high.
    assign write   = writeEn & ~reset;
    assign dataBus = write ? a_q : 8'bz;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH1;
            pc_q    <= RESET_PC;
            a_q     <= 8'h00;
            ir_q    <= 8'h00;
            opnd_q  <= 8'h00;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            ir_q    <= ir_d;
            opnd_q  <= opnd_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        a_d        = a_q;
        ir_d       = ir_q;
        opnd_d     = opnd_q;
        z_d        = z_q;
        c_d        = c_q;
        addressBus = pc_q;
        sync       = 1'b0;
        writeEn    = 1'b0;
        updateZ    = 1'b0;

        case (state_q)
            FETCH1: begin
                sync    = 1'b1;
                ir_d    = dataBus;
                state_d = FETCH2;
            end
            FETCH2: begin
                addressBus = pc_q + 12'd1;
                opnd_d     = dataBus;
                state_d    = EXEC;
            end
            EXEC: begin
                addressBus = operandAddr;
                pc_d       = pc_q + 12'd2;
                state_d    = FETCH1;
                case (opcode)
                    OP_LDA: begin a_d = dataBus; updateZ = 1'b1; end
                    OP_STA: writeEn = 1'b1;
                    OP_ADD: begin
                        {c_d, a_d} = {1'b0, a_q} + {1'b0, dataBus};
                        updateZ    = 1'b1;
                    end
                    OP_SUB: begin
                        a_d     = a_q - dataBus;
                        c_d     = (a_q >= dataBus);
                        updateZ = 1'b1;
                    end
                    OP_AND: begin a_d = a_q & dataBus; updateZ = 1'b1; end
                    OP_OR:  begin a_d = a_q | dataBus; updateZ = 1'b1; end
                    OP_XOR: begin a_d = a_q ^ dataBus; updateZ = 1'b1; end
                    OP_LDI: begin a_d = opnd_q; updateZ = 1'b1; end
                    OP_JMP: pc_d = operandAddr;
                    OP_JZ:  if (z_q)  pc_d = operandAddr;
                    OP_JC:  if (c_q)  pc_d = operandAddr;
                    OP_JNZ: if (!z_q) pc_d = operandAddr;
                    OP_ADC: begin
                        {c_d, a_d} = {1'b0, a_q} + {1'b0, dataBus} + {8'b0, c_q};
                        updateZ    = 1'b1;
                    end
                    OP_SHR: begin
                        c_d     = a_q[0];
                        a_d     = {1'b0, a_q[7:1]};
                        updateZ = 1'b1;
                    end
                    OP_NOP: ;
                    // PC stays on the HLT so the halted bus shows where execution stopped.
                    OP_HLT: begin
                        pc_d    = pc_q;
                        state_d = HALT;
                    end
                    default: ;
                endcase
                if (updateZ) begin
                    z_d = (a_d == 8'h00);
                end
            end
            HALT: begin
                addressBus = pc_q;
            end
            default: state_d = FETCH1;
        endcase
    end

endmodule

// File: tb/tb_spis_cpu.sv
// Directed bench for spis_cpu: a 4Kx8 behavioural memory on the shared bus and
// hand-computed program results checked with immediate assertions.
module tb_spis_cpu;

    logic        clock;
    logic        reset;
    wire  [7:0]  dataBus;
    logic [11:0] addressBus;
    logic        write;
    logic        sync;

    logic [7:0]  mem [4096];
    logic        loadEn;
    logic [11:0] loadAddr;
    logic [7:0]  loadData;

    int total;
    int bad;
    int subFetches;

    spis_cpu dut (
        .clock      (clock),
        .reset      (reset),
        .dataBus    (dataBus),
        .addressBus (addressBus),
        .write      (write),
        .sync       (sync)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory reads are combinational; bench preloads share the single write port.
    assign dataBus = write ? 8'bz : mem[addressBus];

    always @(posedge clock) begin
        if (loadEn) begin
            mem[loadAddr] <= loadData;
        end else if (write) begin
            mem[addressBus] <= dataBus;
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic loadByte(input logic [11:0] addr, input logic [7:0] data);
        loadAddr = addr;
        loadData = data;
        loadEn   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        loadEn   = 1'b0;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        loadEn   = 1'b0;
        loadAddr = 12'h000;
        loadData = 8'h00;
        repeat (2) @(negedge clock);

        checkOutput("resetAddr",  16'(addressBus), 16'h000);
        checkOutput("resetSync",  16'(sync),       16'h1);
        checkOutput("resetWrite", 16'(write),      16'h0);
        checkOutput("resetA",     16'(dut.a_q),    16'h00);
        checkOutput("resetZC",    16'({dut.z_q, dut.c_q}), 16'h0);

        // LDI 05; ADD [100]; STA [101]; HLT
        loadByte(12'h000, 8'h70); loadByte(12'h001, 8'h05);
        loadByte(12'h002, 8'h21); loadByte(12'h003, 8'h00);
        loadByte(12'h004, 8'h11); loadByte(12'h005, 8'h01);
        loadByte(12'h006, 8'hF0); loadByte(12'h007, 8'h00);
        loadByte(12'h100, 8'hFB); loadByte(12'h101, 8'hAA);
        reset = 1'b0;
        checkOutput("firstSync", 16'(sync),       16'h1);
        checkOutput("firstAddr", 16'(addressBus), 16'h000);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            checkOutput($sformatf("addSync%0d", cyc), 16'(sync), 16'((cyc % 3) == 1));
            checkOutput($sformatf("addWrite%0d", cyc), 16'(write), 16'(cyc == 9));
            if (cyc == 9) checkOutput("staAddr", 16'(addressBus), 16'h101);
            applyStimulus(1);
        end
        checkOutput("haltAddr",  16'(addressBus), 16'h006);
        checkOutput("haltSync",  16'(sync),       16'h0);
        checkOutput("haltWrite", 16'(write),      16'h0);
        checkOutput("addStore",  16'(mem[12'h101]), 16'h00);
        checkOutput("addA",      16'(dut.a_q), 16'h00);
        checkOutput("addZ",      16'(dut.z_q), 16'h1);
        checkOutput("addC",      16'(dut.c_q), 16'h1);
        applyStimulus(4);
        checkOutput("haltStay",  16'({sync, addressBus}), 16'h0006);

        // LDI 03; SUB [100]=05; LDI 01; SUB [102]=01
        reset = 1'b1;
        loadByte(12'h000, 8'h70); loadByte(12'h001, 8'h03);
        loadByte(12'h002, 8'h31); loadByte(12'h003, 8'h00);
        loadByte(12'h004, 8'h70); loadByte(12'h005, 8'h01);
        loadByte(12'h006, 8'h31); loadByte(12'h007, 8'h02);
        loadByte(12'h008, 8'hF0); loadByte(12'h009, 8'h00);
        loadByte(12'h100, 8'h05); loadByte(12'h102, 8'h01);
        reset = 1'b0;
        applyStimulus(6);
        checkOutput("subBorrowA", 16'(dut.a_q), 16'h00FE);
        checkOutput("subBorrowZC", 16'({dut.z_q, dut.c_q}), 16'h0);
        applyStimulus(6);
        checkOutput("subEqualA", 16'(dut.a_q), 16'h0000);
        checkOutput("subEqualZC", 16'({dut.z_q, dut.c_q}), 16'h3);

        // LDI 03; SUB [100]=01; JNZ 002; HLT
        reset = 1'b1;
        loadByte(12'h000, 8'h70); loadByte(12'h001, 8'h03);
        loadByte(12'h002, 8'h31); loadByte(12'h003, 8'h00);
        loadByte(12'h004, 8'hB0); loadByte(12'h005, 8'h02);
        loadByte(12'h006, 8'hF0); loadByte(12'h007, 8'h00);
        loadByte(12'h100, 8'h01);
        reset = 1'b0;
        subFetches = 0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            checkOutput($sformatf("loopSync%0d", cyc), 16'(sync), 16'((cyc % 3) == 1));
            if (sync && addressBus == 12'h002) subFetches++;
            applyStimulus(1);
        end
        checkOutput("loopSubCount", 16'(subFetches), 16'd3);
        checkOutput("loopHalt", 16'({sync, addressBus}), 16'h0006);
        checkOutput("loopA", 16'(dut.a_q), 16'h00);

        // JC 008 (not taken); JMP FFE; FFE: NOP -> wraps to 000
        reset = 1'b1;
        loadByte(12'h000, 8'hA0); loadByte(12'h001, 8'h08);
        loadByte(12'h002, 8'h8F); loadByte(12'h003, 8'hFE);
        loadByte(12'hFFE, 8'hE0); loadByte(12'hFFF, 8'h00);
        reset = 1'b0;
        applyStimulus(3);
        checkOutput("jcNotTaken", 16'({sync, addressBus}), 16'h1002);
        applyStimulus(3);
        checkOutput("jmpTarget", 16'({sync, addressBus}), 16'h1FFE);
        applyStimulus(1);
        checkOutput("nopOperand", 16'({sync, addressBus}), 16'h0FFF);
        applyStimulus(2);
        checkOutput("pcWrap", 16'({sync, addressBus}), 16'h1000);

        // JMP FFF; FFF: LDI whose immediate comes from address 000
        reset = 1'b1;
        loadByte(12'h000, 8'h8F); loadByte(12'h001, 8'hFF);
        loadByte(12'hFFF, 8'h70);
        reset = 1'b0;
        applyStimulus(3);
        checkOutput("jmpFFF", 16'({sync, addressBus}), 16'h1FFF);
        applyStimulus(1);
        checkOutput("operandWrap", 16'({sync, addressBus}), 16'h0000);
        applyStimulus(2);
        checkOutput("wrapImmA", 16'(dut.a_q), 16'h008F);
        checkOutput("wrapNextPc", 16'({sync, addressBus}), 16'h1001);

        // LDI 5A; STA [120] interrupted by reset in its execute cycle
        reset = 1'b1;
        loadByte(12'h000, 8'h70); loadByte(12'h001, 8'h5A);
        loadByte(12'h002, 8'h11); loadByte(12'h003, 8'h20);
        loadByte(12'h120, 8'h33);
        reset = 1'b0;
        applyStimulus(5);
        checkOutput("staWriteHigh", 16'({write, addressBus}), 16'h1120);
        reset = 1'b1;
        #1;
        checkOutput("resetKillsWrite", 16'(write), 16'h0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checkOutput("resetMemKept", 16'(mem[12'h120]), 16'h0033);
        checkOutput("resetRestart", 16'({sync, addressBus}), 16'h1000);
        checkOutput("resetClearsA", 16'(dut.a_q), 16'h00);

        // LDI 01; SHR
        reset = 1'b1;
        loadByte(12'h000, 8'h70); loadByte(12'h001, 8'h01);
        loadByte(12'h002, 8'hD0); loadByte(12'h003, 8'h00);
        reset = 1'b0;
        applyStimulus(5);
        checkOutput("shrNoWrite", 16'(write), 16'h0);
        applyStimulus(1);
        checkOutput("shrA", 16'(dut.a_q), 16'h00);
        checkOutput("shrZC", 16'({dut.z_q, dut.c_q}), 16'h3);

        // LDA, AND, OR, XOR, STA, LDI, ADD, ADC, JZ (not taken), STA, HLT
        reset = 1'b1;
        loadByte(12'h000, 8'h01); loadByte(12'h001, 8'h00);
        loadByte(12'h002, 8'h41); loadByte(12'h003, 8'h01);
        loadByte(12'h004, 8'h51); loadByte(12'h005, 8'h02);
        loadByte(12'h006, 8'h61); loadByte(12'h007, 8'h03);
        loadByte(12'h008, 8'h11); loadByte(12'h009, 8'h10);
        loadByte(12'h00A, 8'h70); loadByte(12'h00B, 8'hFF);
        loadByte(12'h00C, 8'h21); loadByte(12'h00D, 8'h04);
        loadByte(12'h00E, 8'hC1); loadByte(12'h00F, 8'h05);
        loadByte(12'h010, 8'h90); loadByte(12'h011, 8'h00);
        loadByte(12'h012, 8'h11); loadByte(12'h013, 8'h11);
        loadByte(12'h014, 8'hF0); loadByte(12'h015, 8'h00);
        loadByte(12'h100, 8'hF0); loadByte(12'h101, 8'h3C);
        loadByte(12'h102, 8'h0F); loadByte(12'h103, 8'hFF);
        loadByte(12'h104, 8'h01); loadByte(12'h105, 8'h01);
        loadByte(12'h110, 8'h00); loadByte(12'h111, 8'h00);
        reset = 1'b0;
        applyStimulus(33);
        checkOutput("mixHalt", 16'({sync, addressBus}), 16'h0014);
        checkOutput("mixLogic", 16'(mem[12'h110]), 16'h00C0);
        checkOutput("mixAdc", 16'(mem[12'h111]), 16'h0002);
        checkOutput("mixZC", 16'({dut.z_q, dut.c_q}), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
